// File: rtl/codec_cfg_sequencer.sv
// WM8731 register-table sequencer driving a 24-bit I2C byte master.
// Power-up settle, table walk with NACK retry, run-time headphone volume.
module codec_cfg_sequencer #(
  parameter int          SETTLE_CYCLES = 50000,
  parameter int          GAP_CYCLES    = 2500,
  parameter int          MAX_RETRY     = 3,
  parameter logic [7:0]  DEV_ADDR      = 8'h34
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREINIT,
  input  logic        iVOL_SET,
  input  logic [6:0]  iVOL,
  output logic        oI2C_GO,
  output logic [23:0] oI2C_DATA,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic [3:0]  oIDX
);

  localparam int CNT_MAX =
    (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [3:0] LAST_IDX = 4'd10;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic [3:0]    r_idx;
  logic [6:0]    r_vol;
  logic          r_vol_mode;
  logic          r_reinit_pend;
  logic          r_ack;
  logic          r_go;
  logic [23:0]   r_data;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_reinit_now;

  function automatic logic [15:0] f_tab(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'h1E00;
      4'd1:    w = 16'h0017;
      4'd2:    w = 16'h0217;
      4'd3:    w = 16'h047B;
      4'd4:    w = 16'h067B;
      4'd5:    w = 16'h0812;
      4'd6:    w = 16'h0A06;
      4'd7:    w = 16'h0C00;
      4'd8:    w = 16'h0E01;
      4'd9:    w = 16'h1002;
      4'd10:   w = 16'h1201;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Volume update reuses idx 2/3 to address R2/R3
  function automatic logic [23:0] f_word(
    input logic [3:0] idx,
    input logic       vm,
    input logic [6:0] vol
  );
    logic [15:0] w;
    if (vm)
      w = {(idx == 4'd3) ? 7'h03 : 7'h02, 2'b01, vol};
    else
      w = f_tab(idx);
    return {DEV_ADDR, w};
  endfunction

  // A reinit during SEND is deferred until the transfer's CHECK cycle
  assign w_reinit_now = (iREINIT && (r_state != S_SEND)) ||
                        ((r_state == S_CHECK) && r_reinit_pend);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state       <= S_WAIT;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_idx         <= '0;
      r_vol         <= '0;
      r_vol_mode    <= 1'b0;
      r_reinit_pend <= 1'b0;
      r_ack         <= 1'b0;
      r_go          <= 1'b0;
      r_data        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else if (w_reinit_now) begin
      r_state       <= S_WAIT;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_idx         <= '0;
      r_vol_mode    <= 1'b0;
      r_reinit_pend <= 1'b0;
      r_go          <= 1'b0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_busy <= 1'b1;
          if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_SEND;
            r_go    <= 1'b1;
            r_data  <= f_word(r_idx, r_vol_mode, r_vol);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SEND: begin
          r_reinit_pend <= r_reinit_pend | iREINIT;
          if (iI2C_END) begin
            r_go    <= 1'b0;
            r_ack   <= iI2C_ACK;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_ack) begin
            r_retry <= '0;
            if (r_vol_mode && (r_idx == 4'd3)) begin
              r_vol_mode <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= S_DONE;
            end else if (!r_vol_mode && (r_idx == LAST_IDX)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_GAP;
            end
          end else if (r_retry < RW'(MAX_RETRY)) begin
            r_retry <= r_retry + 1'b1;
            r_state <= S_GAP;
          end else begin
            r_err      <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_vol_mode <= 1'b0;
            r_state    <= S_ERR;
          end
        end
        S_GAP: begin
          if (r_cnt == CW'(GAP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_SEND;
            r_go    <= 1'b1;
            r_data  <= f_word(r_idx, r_vol_mode, r_vol);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (iVOL_SET) begin
            r_vol      <= iVOL;
            r_vol_mode <= 1'b1;
            r_idx      <= 4'd2;
            r_busy     <= 1'b1;
            r_go       <= 1'b1;
            r_data     <= f_word(4'd2, 1'b1, iVOL);
            r_state    <= S_SEND;
          end
        end
        S_ERR: begin
          r_go <= 1'b0;
        end
        default: begin
          r_state <= S_WAIT;
        end
      endcase
    end
  end

  assign oI2C_GO   = r_go;
  assign oI2C_DATA = r_data;
  assign oBUSY     = r_busy;
  assign oDONE     = r_done;
  assign oERR      = r_err;
  assign oIDX      = r_idx;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural I2C master
// that ends each transfer 10 cycles after GO and can NACK chosen words.
module tb_codec_cfg_sequencer;

  localparam int SETTLE = 20;
  localparam int GAP    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reinit = 1'b0;
  logic        vol_set = 1'b0;
  logic [6:0]  vol = '0;
  logic        go;
  logic [23:0] data;
  logic        i2c_end;
  logic        i2c_ack;
  logic        busy, done, err;
  logic [3:0]  idx;

  logic        m_end = 1'b0;
  logic        m_ack = 1'b0;
  logic        t_end = 1'b0;
  logic        t_ack = 1'b0;

  assign i2c_end = m_end | t_end;
  assign i2c_ack = t_end ? t_ack : m_ack;

  codec_cfg_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .GAP_CYCLES   (GAP),
    .MAX_RETRY    (3),
    .DEV_ADDR     (8'h34)
  ) dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iREINIT   (reinit),
    .iVOL_SET  (vol_set),
    .iVOL      (vol),
    .oI2C_GO   (go),
    .oI2C_DATA (data),
    .iI2C_END  (i2c_end),
    .iI2C_ACK  (i2c_ack),
    .oBUSY     (busy),
    .oDONE     (done),
    .oERR      (err),
    .oIDX      (idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [23:0] q_log[$];
  int          q_gap[$];
  logic [23:0] nack_word = '0;
  int          nack_left = 0;

  initial begin : master
    bit m_active;
    int m_cnt;
    int low;
    m_active = 0;
    m_cnt = 0;
    low = 0;
    forever begin
      @(negedge clk);
      m_end = 1'b0;
      if (!rst_n) begin
        m_active = 0;
        low = 0;
      end else if (m_active) begin
        m_cnt++;
        if (m_cnt == 10) begin
          m_end = 1'b1;
          m_active = 0;
        end
      end else if (go) begin
        m_active = 1;
        m_cnt = 0;
        q_log.push_back(data);
        q_gap.push_back(low);
        low = 0;
        if (data == nack_word && nack_left > 0) begin
          m_ack = 1'b0;
          nack_left--;
        end else begin
          m_ack = 1'b1;
        end
      end else begin
        low++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [23:0] watch_word = '0;

  function automatic bit cond(input int c);
    case (c)
      0: return done && !busy;
      1: return err;
      2: return go;
      3: return !go;
      4: return q_log.size() > 0 && q_log[q_log.size()-1] == watch_word;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int c, input int maxc, input string nm);
    int n;
    n = 0;
    while (!cond(c) && n < maxc) begin
      tick();
      n++;
    end
    chk({nm, " reached"}, {31'd0, cond(c)}, 32'd1);
  endtask

  task automatic count_to_go(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!go && n < 500);
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
  endtask

  task automatic pulse_vol(input logic [6:0] v);
    vol = v;
    vol_set = 1'b1;
    tick();
    vol_set = 1'b0;
  endtask

  function automatic int count_word(input logic [23:0] w);
    int c;
    c = 0;
    foreach (q_log[i]) if (q_log[i] == w) c++;
    return c;
  endfunction

  typedef struct {
    int          idx;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vt[11];

  initial begin
    int n;
    int gmin, gmax, sz;

    vt[0]  = '{0,  24'h341E00};
    vt[1]  = '{1,  24'h340017};
    vt[2]  = '{2,  24'h340217};
    vt[3]  = '{3,  24'h34047B};
    vt[4]  = '{4,  24'h34067B};
    vt[5]  = '{5,  24'h340812};
    vt[6]  = '{6,  24'h340A06};
    vt[7]  = '{7,  24'h340C00};
    vt[8]  = '{8,  24'h340E01};
    vt[9]  = '{9,  24'h341002};
    vt[10] = '{10, 24'h341201};

    // 1: reset state, settle time, full table walk
    tick();
    tick();
    chk("rst go", {31'd0, go}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst idx", {28'd0, idx}, 0);
    rst_n = 1'b1;
    tick();
    chk("busy after release", {31'd0, busy}, 1);
    count_to_go(n);
    chk("settle cycles", n + 1, SETTLE);
    chk("first data", {8'd0, data}, {8'd0, 24'h341E00});
    wait_for(0, 2000, "t1 done");
    chk("t1 xfers", q_log.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < q_log.size())
        chk($sformatf("t1 word %0d", vt[i].idx),
            {8'd0, q_log[i]}, {8'd0, vt[i].exp_data});
    end
    gmin = 1000;
    gmax = 0;
    for (int i = 1; i < q_gap.size(); i++) begin
      if (q_gap[i] < gmin) gmin = q_gap[i];
      if (q_gap[i] > gmax) gmax = q_gap[i];
    end
    chk("gap min", gmin, GAP + 1);
    chk("gap max", gmax, GAP + 1);
    chk("t1 idx", {28'd0, idx}, 10);
    chk("t1 err", {31'd0, err}, 0);

    // 2: NACK entry 3 twice then ACK
    pulse_reinit();
    chk("t2 done cleared", {31'd0, done}, 0);
    q_log.delete();
    q_gap.delete();
    nack_word = 24'h34047B;
    nack_left = 2;
    wait_for(0, 3000, "t2 done");
    chk("t2 retries", count_word(24'h34047B), 3);
    chk("t2 xfers", q_log.size(), 13);
    chk("t2 err", {31'd0, err}, 0);

    // 3: NACK entry 5 past the retry limit
    pulse_reinit();
    q_log.delete();
    q_gap.delete();
    nack_word = 24'h340812;
    nack_left = 4;
    wait_for(1, 3000, "t3 err");
    tick();
    chk("t3 tries", count_word(24'h340812), 4);
    chk("t3 idx", {28'd0, idx}, 5);
    chk("t3 go", {31'd0, go}, 0);
    chk("t3 busy", {31'd0, busy}, 0);
    chk("t3 done", {31'd0, done}, 0);
    sz = q_log.size();
    for (int i = 0; i < 30; i++) tick();
    chk("t3 no more xfers", q_log.size(), sz);
    chk("t3 err held", {31'd0, err}, 1);
    pulse_reinit();
    chk("t3 err cleared", {31'd0, err}, 0);
    q_log.delete();
    q_gap.delete();
    wait_for(2, 200, "t3 restart go");
    tick();
    chk("t3 restart word", {8'd0, q_log[0]}, {8'd0, 24'h341E00});
    wait_for(0, 3000, "t3 done");

    // 4: run-time volume update, second request ignored
    q_log.delete();
    q_gap.delete();
    pulse_vol(7'h50);
    chk("t4 busy", {31'd0, busy}, 1);
    chk("t4 done kept", {31'd0, done}, 1);
    chk("t4 idx", {28'd0, idx}, 2);
    chk("t4 go", {31'd0, go}, 1);
    tick();
    tick();
    pulse_vol(7'h11);
    wait_for(0, 500, "t4 done");
    chk("t4 xfers", q_log.size(), 2);
    if (q_log.size() == 2) begin
      chk("t4 r2", {8'd0, q_log[0]}, {8'd0, 24'h3404D0});
      chk("t4 r3", {8'd0, q_log[1]}, {8'd0, 24'h3406D0});
    end
    chk("t4 idx end", {28'd0, idx}, 3);

    // 5: reinit during SEND of entry 6; vol request in WAIT ignored
    pulse_reinit();
    pulse_vol(7'h33);
    q_log.delete();
    q_gap.delete();
    watch_word = 24'h340A06;
    wait_for(4, 3000, "t5 entry6");
    tick();
    tick();
    pulse_reinit();
    chk("t5 go held", {31'd0, go}, 1);
    wait_for(3, 100, "t5 go drop");
    n = 1;
    while (!go && n < 500) begin
      tick();
      if (!go) n++;
    end
    chk("t5 wait len", n, SETTLE + 1);
    sz = q_log.size();
    chk("t5 xfers", sz, 8);
    if (sz >= 2) begin
      chk("t5 last old", {8'd0, q_log[sz-2]}, {8'd0, 24'h340A06});
      chk("t5 restart", {8'd0, q_log[sz-1]}, {8'd0, 24'h341E00});
    end
    wait_for(0, 3000, "t5 done");

    // 6: reset mid-transfer; stray END while in reset
    pulse_vol(7'h22);
    tick();
    chk("t6 go before", {31'd0, go}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 go", {31'd0, go}, 0);
    chk("t6 done", {31'd0, done}, 0);
    chk("t6 err", {31'd0, err}, 0);
    chk("t6 idx", {28'd0, idx}, 0);
    chk("t6 busy", {31'd0, busy}, 0);
    t_ack = 1'b1;
    t_end = 1'b1;
    tick();
    tick();
    t_end = 1'b0;
    q_log.delete();
    q_gap.delete();
    rst_n = 1'b1;
    count_to_go(n);
    chk("t6 settle", n, SETTLE);
    chk("t6 first data", {8'd0, data}, {8'd0, 24'h341E00});
    wait_for(0, 3000, "t6 done");
    chk("t6 xfers", q_log.size(), 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
